// File: rtl/sdram_pkg.sv
// Shared types and defaults for the SDRAM port arbiter: client port ids,
// sequencer states and default timing constants.
package sdram_pkg;

    typedef enum logic [1:0] {
        PORT_DL  = 2'd0,
        PORT_VID = 2'd1,
        PORT_CPU = 2'd2
    } port_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int SETTLE_CYC_DEF = 2;
    localparam int TIMEOUT_DEF    = 255;
    localparam int AW_DEF         = 25;

endpackage

// File: rtl/sdram_prio_enc.sv
// Fixed-priority grant encoder: download beats video beats CPU.
module sdram_prio_enc
    import sdram_pkg::*;
(
    input  logic       dl_req,
    input  logic       vid_req,
    input  logic       cpu_req,
    output logic [1:0] grant_id,
    output logic       grant_vld
);

    // Pick the highest-priority pending request
    always_comb begin
        grant_id  = PORT_DL;
        grant_vld = 1'b0;
        if (dl_req) begin
            grant_id  = PORT_DL;
            grant_vld = 1'b1;
        end else if (vid_req) begin
            grant_id  = PORT_VID;
            grant_vld = 1'b1;
        end else if (cpu_req) begin
            grant_id  = PORT_CPU;
            grant_vld = 1'b1;
        end else begin
            grant_id  = PORT_DL;
            grant_vld = 1'b0;
        end
    end

endmodule

// File: rtl/sdram_port_arb.sv
// Three-client arbiter/sequencer in front of the edge-triggered SDRAM
// controller; each client sees a level req / one-cycle ack handshake.
module sdram_port_arb
    import sdram_pkg::*;
#(
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF,
    parameter int AW         = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dl_req,
    input  logic [AW-1:0] dl_addr,
    input  logic [7:0]    dl_data,
    output logic          dl_ack,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [15:0]   vid_dout,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_ack,
    output logic [15:0]   cpu_dout,
    output logic [AW-1:0] sd_addr,
    output logic [7:0]    sd_din,
    output logic          sd_we,
    output logic          sd_rd,
    input  logic          sd_ready,
    input  logic [15:0]   sd_dout,
    output logic          timeout_err
);

    state_e        state_q, state_d;
    port_e         port_q, port_d;
    logic [7:0]    settle_q, settle_d;
    logic [7:0]    tmo_q, tmo_d;
    logic [AW-1:0] sd_addr_q, sd_addr_d;
    logic [7:0]    sd_din_q, sd_din_d;
    logic          sd_we_q, sd_we_d, sd_rd_q, sd_rd_d;
    logic          dl_ack_q, dl_ack_d, vid_ack_q, vid_ack_d, cpu_ack_q, cpu_ack_d;
    logic [15:0]   vid_dout_q, vid_dout_d, cpu_dout_q, cpu_dout_d;
    logic          err_q, err_d;

    logic [1:0]    grant_id_s;
    logic          grant_vld_s;
    logic          grant_s, wait_ok_s, wait_tmo_s;

    sdram_prio_enc u_prio (
        .dl_req    (dl_req),
        .vid_req   (vid_req),
        .cpu_req   (cpu_req),
        .grant_id  (grant_id_s),
        .grant_vld (grant_vld_s)
    );

    // No grant while the controller is busy or still starting up
    assign grant_s    = grant_vld_s && sd_ready;
    assign wait_ok_s  = (settle_q == 8'd0) && sd_ready;
    assign wait_tmo_s = (tmo_q == 8'(TIMEOUT - 1)) && !wait_ok_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = grant_s ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  state_d = (wait_ok_s || wait_tmo_s) ? ST_DONE : ST_WAIT;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values; acks default low so they pulse once
    always_comb begin
        port_d     = port_q;
        settle_d   = settle_q;
        tmo_d      = tmo_q;
        sd_addr_d  = sd_addr_q;
        sd_din_d   = sd_din_q;
        sd_we_d    = sd_we_q;
        sd_rd_d    = sd_rd_q;
        dl_ack_d   = 1'b0;
        vid_ack_d  = 1'b0;
        cpu_ack_d  = 1'b0;
        vid_dout_d = vid_dout_q;
        cpu_dout_d = cpu_dout_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    port_d = port_e'(grant_id_s);
                    case (port_e'(grant_id_s))
                        PORT_DL: begin
                            sd_addr_d = dl_addr;
                            sd_din_d  = dl_data;
                        end
                        PORT_VID: sd_addr_d = vid_addr;
                        PORT_CPU: sd_addr_d = cpu_addr;
                        default:  sd_addr_d = sd_addr_q;
                    endcase
                end else begin
                    port_d = port_q;
                end
            end
            ST_ISSUE: begin
                sd_we_d  = (port_q == PORT_DL);
                sd_rd_d  = (port_q != PORT_DL);
                settle_d = 8'(SETTLE_CYC);
                tmo_d    = 8'd0;
            end
            ST_WAIT: begin
                if (settle_q != 8'd0) begin
                    settle_d = settle_q - 8'd1;
                end else begin
                    settle_d = settle_q;
                end
                tmo_d = tmo_q + 8'd1;
                if (wait_tmo_s) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
            end
            ST_DONE: begin
                sd_we_d = 1'b0;
                sd_rd_d = 1'b0;
                case (port_q)
                    PORT_DL:  dl_ack_d = 1'b1;
                    PORT_VID: begin
                        vid_ack_d  = 1'b1;
                        vid_dout_d = sd_dout;
                    end
                    PORT_CPU: begin
                        cpu_ack_d  = 1'b1;
                        cpu_dout_d = sd_dout;
                    end
                    default: dl_ack_d = 1'b0;
                endcase
            end
            default: begin
                sd_we_d = 1'b0;
                sd_rd_d = 1'b0;
            end
        endcase
    end

    // Registered datapath and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_q     <= PORT_DL;
            settle_q   <= 8'd0;
            tmo_q      <= 8'd0;
            sd_addr_q  <= '0;
            sd_din_q   <= 8'd0;
            sd_we_q    <= 1'b0;
            sd_rd_q    <= 1'b0;
            dl_ack_q   <= 1'b0;
            vid_ack_q  <= 1'b0;
            cpu_ack_q  <= 1'b0;
            vid_dout_q <= 16'd0;
            cpu_dout_q <= 16'd0;
            err_q      <= 1'b0;
        end else begin
            port_q     <= port_d;
            settle_q   <= settle_d;
            tmo_q      <= tmo_d;
            sd_addr_q  <= sd_addr_d;
            sd_din_q   <= sd_din_d;
            sd_we_q    <= sd_we_d;
            sd_rd_q    <= sd_rd_d;
            dl_ack_q   <= dl_ack_d;
            vid_ack_q  <= vid_ack_d;
            cpu_ack_q  <= cpu_ack_d;
            vid_dout_q <= vid_dout_d;
            cpu_dout_q <= cpu_dout_d;
            err_q      <= err_d;
        end
    end

    assign sd_addr     = sd_addr_q;
    assign sd_din      = sd_din_q;
    assign sd_we       = sd_we_q;
    assign sd_rd       = sd_rd_q;
    assign dl_ack      = dl_ack_q;
    assign vid_ack     = vid_ack_q;
    assign cpu_ack     = cpu_ack_q;
    assign vid_dout    = vid_dout_q;
    assign cpu_dout    = cpu_dout_q;
    assign timeout_err = err_q;

endmodule
